// File: rtl/cp0_tlb_seq.sv
// CP0 TLB instruction sequencer: drives TLBP/TLBR/TLBWI/TLBWR onto the shared
// TLB array port, stalls the pipeline until done, and owns the Random register.
module cp0_tlb_seq #(
    parameter int unsigned N_ENTRIES = 16,
    parameter int unsigned IDX_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [1:0]       req_op,
    output logic             req_ready,
    input  logic             flush,
    input  logic [IDX_W-1:0] cp0_index,
    input  logic [IDX_W-1:0] cp0_wired,
    input  logic             wired_we,
    output logic             tlb_valid,
    input  logic             tlb_ready,
    output logic [1:0]       tlb_kind,
    output logic [IDX_W-1:0] tlb_idx,
    input  logic             tlb_resp_valid,
    input  logic             tlb_resp_hit,
    input  logic [IDX_W-1:0] tlb_resp_idx,
    output logic             stall,
    output logic             index_we,
    output logic [31:0]      index_wd,
    output logic             entry_we,
    output logic [IDX_W-1:0] random,
    output logic             busy
);

    localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(N_ENTRIES - 1);

    localparam logic [1:0] OP_TLBP  = 2'd0;
    localparam logic [1:0] OP_TLBR  = 2'd1;
    localparam logic [1:0] OP_TLBWR = 2'd3;

    localparam logic [1:0] KIND_PROBE = 2'd0;
    localparam logic [1:0] KIND_READ  = 2'd1;
    localparam logic [1:0] KIND_WRITE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_op;
    logic [1:0]       w_op_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             r_squash;
    logic             w_squash_nxt;
    logic [IDX_W-1:0] r_random;
    logic             w_is_write;
    logic [1:0]       w_kind;

    // Both TLBWI and TLBWR (op[1] set) complete at the handshake, no response.
    assign w_is_write = r_op[1];
    assign w_kind     = (r_op == OP_TLBP) ? KIND_PROBE :
                        (r_op == OP_TLBR) ? KIND_READ  : KIND_WRITE;
    assign random     = r_random;

    // FSM state, latched operation/target and squash flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_op     <= 2'd0;
            r_idx    <= '0;
            r_squash <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_op     <= w_op_nxt;
            r_idx    <= w_idx_nxt;
            r_squash <= w_squash_nxt;
        end
    end

    // Random: free-running down-counter, reloads to the top at or below Wired
    always_ff @(posedge clk) begin
        if (reset) begin
            r_random <= RAND_TOP;
        end else if (wired_we || (r_random <= cp0_wired)) begin
            r_random <= RAND_TOP;
        end else begin
            r_random <= r_random - IDX_W'(1);
        end
    end

    // Next-state, array request and CP0 strobe generation
    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_idx_nxt    = r_idx;
        w_squash_nxt = r_squash;
        req_ready    = 1'b0;
        tlb_valid    = 1'b0;
        tlb_kind     = w_kind;
        tlb_idx      = r_idx;
        stall        = 1'b0;
        index_we     = 1'b0;
        index_wd     = 32'h0;
        entry_we     = 1'b0;
        busy         = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                req_ready    = 1'b1;
                stall        = req_valid;
                w_squash_nxt = 1'b0;
                if (req_valid && !flush) begin
                    w_op_nxt    = req_op;
                    w_idx_nxt   = (req_op == OP_TLBWR) ? r_random : cp0_index;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tlb_valid = 1'b1;
                stall     = 1'b1;
                if (tlb_ready) begin
                    // Array has taken the op; a concurrent flush only squashes results.
                    w_state_nxt = w_is_write ? S_DONE : S_WAIT;
                    if (flush && !w_is_write) begin
                        w_squash_nxt = 1'b1;
                    end
                end else if (flush) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (flush) begin
                    w_squash_nxt = 1'b1;
                end
                if (tlb_resp_valid) begin
                    w_state_nxt = S_DONE;
                    if (!(r_squash || flush)) begin
                        if (r_op == OP_TLBP) begin
                            index_we = 1'b1;
                            index_wd = {!tlb_resp_hit,
                                        31'(tlb_resp_hit ? tlb_resp_idx : IDX_W'(0))};
                        end else begin
                            entry_we = 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                w_squash_nxt = 1'b0;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Reset silences the array port and CP0 strobes in the same cycle.
        if (reset) begin
            tlb_valid = 1'b0;
            index_we  = 1'b0;
            index_wd  = 32'h0;
            entry_we  = 1'b0;
            stall     = 1'b0;
        end
    end

endmodule

// File: tb/tb_cp0_tlb_seq.sv
// Self-checking bench for cp0_tlb_seq: scoreboarded array requests and CP0
// updates plus a reference model of the Random register.
module tb_cp0_tlb_seq;

    localparam int unsigned N = 16;
    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic [1:0]   req_op;
    logic         req_ready;
    logic         flush;
    logic [W-1:0] cp0_index;
    logic [W-1:0] cp0_wired;
    logic         wired_we;
    logic         tlb_valid;
    logic         tlb_ready;
    logic [1:0]   tlb_kind;
    logic [W-1:0] tlb_idx;
    logic         tlb_resp_valid;
    logic         tlb_resp_hit;
    logic [W-1:0] tlb_resp_idx;
    logic         stall;
    logic         index_we;
    logic [31:0]  index_wd;
    logic         entry_we;
    logic [W-1:0] random;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    // {check_idx, kind, idx} per expected array handshake
    logic [W+2:0] q_arr [$];
    // {is_entry, index_wd} per expected CP0 update
    logic [32:0]  q_cp0 [$];
    logic [W+2:0] e_arr;
    logic [32:0]  e_cp0;

    logic [W-1:0] m_random;
    logic         mon_en = 1'b0;

    always #5 clk = ~clk;

    cp0_tlb_seq #(.N_ENTRIES(N), .IDX_W(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready),
        .flush(flush), .cp0_index(cp0_index), .cp0_wired(cp0_wired),
        .wired_we(wired_we),
        .tlb_valid(tlb_valid), .tlb_ready(tlb_ready), .tlb_kind(tlb_kind),
        .tlb_idx(tlb_idx), .tlb_resp_valid(tlb_resp_valid),
        .tlb_resp_hit(tlb_resp_hit), .tlb_resp_idx(tlb_resp_idx),
        .stall(stall), .index_we(index_we), .index_wd(index_wd),
        .entry_we(entry_we), .random(random), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Random register reference
    always @(posedge clk) begin
        if (reset)
            m_random <= W'(N - 1);
        else if (wired_we || (m_random <= cp0_wired))
            m_random <= W'(N - 1);
        else
            m_random <= m_random - W'(1);
    end

    // Output monitor: pops scoreboard entries when the DUT produces them
    always @(negedge clk) begin
        if (mon_en) begin
            check("random_model", 64'(random), 64'(m_random));
            if (tlb_valid && tlb_ready) begin
                if (q_arr.size() == 0) begin
                    check("arr_unexpected", 64'(1), 64'(0));
                end else begin
                    e_arr = q_arr.pop_front();
                    check("arr_kind", 64'(tlb_kind), 64'(e_arr[W+1:W]));
                    if (e_arr[W+2]) check("arr_idx", 64'(tlb_idx), 64'(e_arr[W-1:0]));
                end
            end
            if (index_we || entry_we) begin
                if (q_cp0.size() == 0) begin
                    check("cp0_unexpected", 64'({entry_we, index_we}), 64'(0));
                end else begin
                    e_cp0 = q_cp0.pop_front();
                    check("cp0_strobe", 64'({entry_we, index_we}),
                          64'(e_cp0[32] ? 2'b10 : 2'b01));
                    if (index_we) check("index_wd", 64'(index_wd), 64'(e_cp0[31:0]));
                end
            end
        end
    end

    // One complete instruction starting from IDLE
    task automatic run_op(input logic [1:0] op, input int rdy_lat, input int resp_lat,
                          input logic hit, input logic [W-1:0] ridx, input logic flush_wait);
        logic [1:0]   kind;
        logic [W-1:0] eidx;
        kind = (op == 2'd0) ? 2'd0 : (op == 2'd1) ? 2'd1 : 2'd2;
        eidx = (op == 2'd3) ? m_random : cp0_index;
        req_valid = 1'b1;
        req_op    = op;
        q_arr.push_back({(op != 2'd0), kind, eidx});
        at_neg();
        check("stall_idle", 64'(stall), 64'(1));
        check("req_ready", 64'(req_ready), 64'(1));
        tick();
        req_valid = 1'b0;
        req_op    = 2'd0;
        for (int i = 0; i < rdy_lat; i++) begin
            at_neg();
            check("issue_valid", 64'(tlb_valid), 64'(1));
            check("issue_kind", 64'(tlb_kind), 64'(kind));
            if (op != 2'd0) check("issue_idx", 64'(tlb_idx), 64'(eidx));
            check("issue_stall", 64'(stall), 64'(1));
            tick();
        end
        tlb_ready = 1'b1;
        at_neg();
        check("hs_valid", 64'(tlb_valid), 64'(1));
        tick();
        tlb_ready = 1'b0;
        if (!op[1]) begin
            for (int i = 0; i < resp_lat - 1; i++) begin
                if (flush_wait && i == 0) flush = 1'b1;
                at_neg();
                check("wait_stall", 64'(stall), 64'(1));
                check("wait_no_req", 64'(tlb_valid), 64'(0));
                tick();
                flush = 1'b0;
            end
            tlb_resp_valid = 1'b1;
            tlb_resp_hit   = hit;
            tlb_resp_idx   = ridx;
            if (!flush_wait)
                q_cp0.push_back((op == 2'd0) ? {1'b0, (hit ? 32'(ridx) : 32'h8000_0000)}
                                             : {1'b1, 32'h0});
            at_neg();
            tick();
            tlb_resp_valid = 1'b0;
            tlb_resp_hit   = 1'b0;
            tlb_resp_idx   = '0;
        end
        at_neg();
        check("done_stall", 64'(stall), 64'(0));
        check("done_busy", 64'(busy), 64'(1));
        check("done_no_req", 64'(tlb_valid), 64'(0));
        tick();
        at_neg();
        check("idle_busy", 64'(busy), 64'(0));
        tick();
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = 2'd0; flush = 1'b0;
        cp0_index = W'(5); cp0_wired = W'(3); wired_we = 1'b0;
        tlb_ready = 1'b0; tlb_resp_valid = 1'b0; tlb_resp_hit = 1'b0; tlb_resp_idx = '0;

        // Reset state
        tick(); tick();
        at_neg();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_stall", 64'(stall), 64'(0));
        check("rst_random", 64'(random), 64'(15));
        check("rst_valid", 64'(tlb_valid), 64'(0));
        check("rst_strobes", 64'({index_we, entry_we}), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(1));
        mon_en = 1'b1;
        tick();
        reset = 1'b0;

        // Random counts 15..3 with Wired=3, then wraps to 15
        for (int i = 0; i < 13; i++) begin
            at_neg();
            check("rand_seq", 64'(random), 64'(15 - i));
            tick();
        end
        at_neg();
        check("rand_wrap", 64'(random), 64'(15));
        tick();

        // TLBWI idx 5, immediate ready
        run_op(2'd2, 0, 0, 1'b0, '0, 1'b0);
        // TLBP hit idx 9 after 3 cycles, then miss after 1
        run_op(2'd0, 0, 3, 1'b1, W'(9), 1'b0);
        run_op(2'd0, 1, 1, 1'b0, W'(2), 1'b0);
        // TLBR with ready held low 4 cycles
        cp0_index = W'(12);
        run_op(2'd1, 4, 2, 1'b0, '0, 1'b0);

        // Wired write at random=7 forces reload
        for (int i = 0; i < 40 && random != W'(7); i++) tick();
        check("rand_reach7", 64'(random), 64'(7));
        wired_we = 1'b1;
        tick();
        wired_we = 1'b0;
        at_neg();
        check("rand_wired_we", 64'(random), 64'(15));
        tick();

        // TLBWR latched at random=10 while Random keeps counting
        for (int i = 0; i < 40 && random != W'(10); i++) tick();
        check("rand_reach10", 64'(random), 64'(10));
        run_op(2'd3, 2, 0, 1'b0, '0, 1'b0);

        // Flush in IDLE blocks acceptance
        req_valid = 1'b1; req_op = 2'd2; flush = 1'b1;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        at_neg();
        check("flush_idle_busy", 64'(busy), 64'(0));
        tick();

        // Flush in ISSUE before handshake
        req_valid = 1'b1; req_op = 2'd2;
        tick();
        req_valid = 1'b0; flush = 1'b1;
        at_neg();
        check("flush_issue_valid", 64'(tlb_valid), 64'(1));
        tick();
        flush = 1'b0;
        tlb_ready = 1'b1;
        at_neg();
        check("flush_issue_busy", 64'(busy), 64'(0));
        check("flush_issue_noreq", 64'(tlb_valid), 64'(0));
        tick();
        tlb_ready = 1'b0;

        // Flush during TLBR WAIT: response consumed, no entry_we
        run_op(2'd1, 0, 3, 1'b0, '0, 1'b1);

        // Wired at top holds Random at 15
        cp0_wired = W'(15);
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check("rand_hold", 64'(random), 64'(15));
            tick();
        end
        cp0_wired = W'(3);
        tick(); tick(); tick();

        // Reset during WAIT, then a late response
        req_valid = 1'b1; req_op = 2'd0;
        q_arr.push_back({1'b0, 2'd0, W'(0)});
        tick();
        req_valid = 1'b0; tlb_ready = 1'b1;
        tick();
        tlb_ready = 1'b0;
        at_neg();
        check("rstw_wait_stall", 64'(stall), 64'(1));
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        at_neg();
        check("rstw_busy", 64'(busy), 64'(0));
        check("rstw_stall", 64'(stall), 64'(0));
        check("rstw_random", 64'(random), 64'(15));
        tick();
        tlb_resp_valid = 1'b1; tlb_resp_hit = 1'b1; tlb_resp_idx = W'(3);
        at_neg();
        check("rstw_late_resp", 64'({index_we, entry_we}), 64'(0));
        tick();
        tlb_resp_valid = 1'b0; tlb_resp_hit = 1'b0;
        tick(); tick();

        check("q_arr_empty", 64'(q_arr.size()), 64'(0));
        check("q_cp0_empty", 64'(q_cp0.size()), 64'(0));
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
